// File: rtl/stunir_call_pkg.sv
// Shared types for the generated-function call initiator.
// State encodings, status codes and result width.
package stunir_call_pkg;

    localparam int RESULT_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_BAD_SEL = 2'b10
    } status_t;

endpackage

// File: rtl/stunir_call_timer.sv
// Call timeout counter covering the ARM and WAIT states.
// expired flags the last cycle a call may still complete.
module stunir_call_timer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_q;

    // Count cycles since the last clear while enabled.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/stunir_call_initiator.sv
// Start/done/result handshake initiator for generated functions.
// One call in flight; reports OK, TIMEOUT or BAD_SEL per call.
module stunir_call_initiator
    import stunir_call_pkg::*;
#(
    parameter int NUM_CALLEES = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT     = 1024,
    parameter int TO_W        = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [SEL_W-1:0]                req_sel,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [SEL_W-1:0]                rsp_sel,
    output logic [RESULT_W-1:0]             rsp_result,
    output logic [1:0]                      rsp_status,
    output logic                            busy,
    output logic [NUM_CALLEES-1:0]          callee_start,
    input  logic [NUM_CALLEES-1:0]          callee_done,
    input  logic [NUM_CALLEES*RESULT_W-1:0] callee_result
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [RESULT_W-1:0] result_q;
    status_t             status_q;

    logic                sel_ok;
    logic                load_req, cap_ok, cap_to;
    logic                cur_done;
    logic [RESULT_W-1:0] cur_res;
    logic                expired;

    assign sel_ok = 32'(req_sel) < 32'(NUM_CALLEES);

    stunir_call_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == START),
        .enable  ((state_q == ARM) || (state_q == WAIT)),
        .expired (expired)
    );

    // Select the active callee's done/result and drive its start pulse.
    always_comb begin
        cur_done     = 1'b0;
        cur_res      = '0;
        callee_start = '0;
        for (int i = 0; i < NUM_CALLEES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_done        = callee_done[i];
                cur_res         = callee_result[i*RESULT_W +: RESULT_W];
                callee_start[i] = (state_q == START);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a stale done is drained in ARM before WAIT looks at it.
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        cap_ok   = 1'b0;
        cap_to   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = sel_ok ? START : RESP;
                end
            end
            START: state_d = ARM;
            ARM: begin
                if (expired) begin
                    cap_to  = 1'b1;
                    state_d = RESP;
                end else if (!cur_done) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cur_done) begin
                    cap_ok  = 1'b1;
                    state_d = RESP;
                end else if (expired) begin
                    cap_to  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response registers: select, result and status of the current call.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            result_q <= '0;
            status_q <= ST_OK;
        end else if (load_req) begin
            sel_q    <= req_sel;
            result_q <= '0;
            status_q <= sel_ok ? ST_OK : ST_BAD_SEL;
        end else if (cap_ok) begin
            result_q <= cur_res;
            status_q <= ST_OK;
        end else if (cap_to) begin
            result_q <= '0;
            status_q <= ST_TIMEOUT;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_sel    = sel_q;
    assign rsp_result = result_q;
    assign rsp_status = status_q;
    assign busy       = (state_q != IDLE);

endmodule
